// File: rtl/run_stream_gen_if.sv
// Command handshake for run_stream_gen: one (bit, length) command per accepted transfer.
interface run_stream_gen_if #(
  parameter int unsigned LEN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic [LEN_W-1:0] in_len;

  modport master (
    output in_valid,
    output in_bit,
    output in_len,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  in_len,
    output in_ready
  );
endinterface

// File: rtl/run_stream_gen.sv
// Run-length serializer: turns (bit, length) commands into a cen-qualified bit stream,
// with a one-deep pending slot so consecutive runs stream without a gap.
module run_stream_gen #(
  parameter int unsigned LEN_W = 4
) (
  input  logic           clk,
  input  logic           resetn,
  run_stream_gen_if.slave cmd,
  input  logic           hold,
  output logic           dout,
  output logic           cen,
  output logic           last,
  output logic           busy
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           r_state, w_state_nxt;
  logic             r_cur_bit, w_cur_bit_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pend_valid, w_pend_valid_nxt;
  logic             r_pend_bit, w_pend_bit_nxt;
  logic [LEN_W-1:0] r_pend_len, w_pend_len_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_cen, w_cen_nxt;
  logic             r_last, w_last_nxt;

  logic w_take;
  logic w_cnt_one;

  assign cmd.in_ready = !r_pend_valid;
  assign busy         = (r_state == StEmit) || r_pend_valid;
  assign dout         = r_dout;
  assign cen          = r_cen;
  assign last         = r_last;

  // Zero-length commands complete the handshake but are otherwise ignored.
  assign w_take    = cmd.in_valid && !r_pend_valid && (cmd.in_len != '0);
  assign w_cnt_one = (r_cnt == LEN_W'(1));

  always_comb begin
    w_state_nxt      = r_state;
    w_cur_bit_nxt    = r_cur_bit;
    w_cnt_nxt        = r_cnt;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_bit_nxt   = r_pend_bit;
    w_pend_len_nxt   = r_pend_len;
    w_dout_nxt       = r_dout;
    w_cen_nxt        = 1'b0;
    w_last_nxt       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_take) begin
          w_cur_bit_nxt = cmd.in_bit;
          w_cnt_nxt     = cmd.in_len;
          w_state_nxt   = StEmit;
        end
      end
      StEmit: begin
        if (!hold) begin
          w_cen_nxt  = 1'b1;
          w_dout_nxt = r_cur_bit;
          w_last_nxt = w_cnt_one;
          w_cnt_nxt  = r_cnt - 1'b1;
        end
        if (!hold && w_cnt_one) begin
          // Finishing edge: pending command first, then a same-edge accept, else idle.
          if (r_pend_valid) begin
            w_cur_bit_nxt    = r_pend_bit;
            w_cnt_nxt        = r_pend_len;
            w_pend_valid_nxt = 1'b0;
          end else if (w_take) begin
            w_cur_bit_nxt = cmd.in_bit;
            w_cnt_nxt     = cmd.in_len;
          end else begin
            w_state_nxt = StIdle;
          end
        end else if (w_take) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_bit_nxt   = cmd.in_bit;
          w_pend_len_nxt   = cmd.in_len;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_cur_bit    <= 1'b0;
      r_cnt        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_bit   <= 1'b0;
      r_pend_len   <= '0;
      r_dout       <= 1'b0;
      r_cen        <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_bit    <= w_cur_bit_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_bit   <= w_pend_bit_nxt;
      r_pend_len   <= w_pend_len_nxt;
      r_dout       <= w_dout_nxt;
      r_cen        <= w_cen_nxt;
      r_last       <= w_last_nxt;
    end
  end

endmodule
